jnwtr_ckdivn_cv: RTL
====================

# jnwtr_ckdivn_cv

Programmable integer clock divider, the parametrised successor to the fixed divide-by-2 cell in the JNWTR digital library. It divides the input clock by a runtime ratio of 2 to 2^W−1 and produces two outputs: a near-50%-duty divided clock and a one-cycle period-start strobe. Ratio changes are glitch-free because a new ratio is applied only at a period boundary. The block sits between the reference clock and downstream sequencing and SAR timing logic.

## Interface
- W, 8, width of the ratio input and of the internal counter.
- DIV_RST, 2, active ratio after reset. Legal range is 2..2^W−1.

Ports:
- CKI  input  1  clock. All logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  run enable. Low stops the divider and forces the outputs low.
- DIV  input  W  requested ratio N.
- DIV_LD  input  1  one-cycle load strobe that captures DIV into the pending register.
- CKO50DC  output  1  divided clock, high for ceil(N/2) of every N cycles.
- CKO  output  1  one-CKI-cycle strobe at the start of each divided period.
- PEND  output  1  a loaded ratio is waiting for the next boundary.
- DIV_ACT  output  W  ratio currently in use.

## Operation
- Clamp rule: any DIV value below 2 is treated as 2 at capture. The stored pending or active ratio is therefore always in 2..2^W−1.
- Registers:
  - cnt (W bits)
  - act (W bits), driven onto DIV_ACT
  - pnd (W bits)
  - PEND
  - state in {IDLE, RUN}
  - registered CKO and CKO50DC
- Reset values: state=IDLE, cnt=0, act=DIV_RST, pnd=DIV_RST, PEND=0, CKO=0, CKO50DC=0.
- Behaviour in IDLE:
  - Outputs are low and cnt=0.
  - A DIV_LD in IDLE writes act directly and leaves PEND=0.
  - On an edge with EN=1: if PEND=1, act<=pnd and PEND<=0. Then cnt<=0, CKO<=1, CKO50DC<=1, and state goes to RUN.
- Behaviour in RUN, per edge:
  - If cnt==act−1 (wrap): cnt<=0 and CKO<=1. If PEND=1, act<=pnd and PEND<=0.
  - Otherwise: cnt<=cnt+1 and CKO<=0.
  - CKO50DC<=(cnt_next < ceil(act_next/2)). The high-time count is computed from the ratio that applies after the edge.
- DIV_LD in RUN:
  - pnd<=clamp(DIV) and PEND<=1.
  - A second DIV_LD before the boundary overwrites pnd. The last value wins.
  - A DIV_LD on the wrap edge itself is applied at that same boundary: act<=clamp(DIV) and PEND stays 0.
- EN low in RUN: at the next edge, state<=IDLE, cnt<=0 and both outputs go to 0. The pending ratio is retained.
- RST has priority over EN and DIV_LD. RST asserted mid-period returns every register to its reset value at that edge.
- Arithmetic rules:
  - cnt never exceeds act−1, so no overflow is possible.
  - ceil(N/2) is computed as (N+1)>>1 in W+1 bits.

## Timing
- All outputs are registered, so there are no combinational paths from input to output.
- Start latency: CKO and CKO50DC go high at the first edge with EN=1 in IDLE, which is one cycle after EN rises.
- Period: exactly act CKI cycles between CKO strobes.
- Duty cycle: CKO50DC is high for ceil(N/2) cycles and low for floor(N/2) cycles. This is exactly 50% for even N.
- Ratio change:
  - The old ratio completes its current period.
  - The first full period at the new ratio begins with the next CKO strobe.
  - DIV_ACT updates on that same edge.
- PEND goes high on the edge after DIV_LD and clears on the boundary edge.
- Stop latency: one edge after EN falls or RST rises.

## Test plan
- Even ratio: RST pulse, then DIV=4 with DIV_LD, then EN=1 → CKO50DC repeats 1100 and CKO repeats 1000, starting on the edge after EN rises. DIV_ACT=4.
- Odd ratio: DIV=5 → CKO50DC repeats 11100 and CKO repeats 10000. DIV=255 (W=8) → 128 cycles high, 127 low.
- Mid-period change: running at N=4, pulse DIV_LD with DIV=6 at cnt=1 → PEND=1 for 3 cycles. The current period ends with 4 cycles total, then CKO50DC runs 111000 and DIV_ACT=6.
- Load on wrap edge and clamp: pulse DIV_LD with DIV=3 exactly on the edge where cnt==act−1 → the next period is 3 cycles (110) and PEND never rises. DIV=0 or DIV=1 → ratio 2, pattern 10.
- Overwrite: while running at N=8, issue two DIV_LD pulses (DIV=3, then DIV=7) within one period → the next period uses 7.
- Stop and reset: EN falls mid-period → outputs 0 on the next edge. EN re-asserted → restart at cnt=0 with CKO=1. RST asserted mid-period → every output at its reset value on that edge and DIV_ACT=DIV_RST.

Source files
------------

// File: rtl/jnwtr_ckdivn_cv_if.sv
// Control and status bundle of the programmable clock divider; master side drives run/ratio, slave side is the divider.
// Pure wiring, no timing of its own; there is no backpressure, every input is sampled on each CKI edge.
interface jnwtr_ckdivn_cv_if #(
  parameter int W = 8
) ();
  logic         EN;
  logic [W-1:0] DIV;
  logic         DIV_LD;
  logic         CKO50DC;
  logic         CKO;
  logic         PEND;
  logic [W-1:0] DIV_ACT;

  modport master (
    output EN, DIV, DIV_LD,
    input  CKO50DC, CKO, PEND, DIV_ACT
  );

  modport slave (
    input  EN, DIV, DIV_LD,
    output CKO50DC, CKO, PEND, DIV_ACT
  );
endinterface

// File: rtl/jnwtr_ckdivn_cv.sv
// Integer clock divider (ratio 2..2^W-1) with near-50% clock and period-start strobe; outputs registered, first strobe one edge after EN.
// No backpressure: a new ratio waits in a pending register and is adopted only at the next period boundary.
module jnwtr_ckdivn_cv #(
  parameter int W       = 8,
  parameter int DIV_RST = 2
) (
  input logic              CKI,
  input logic              RST,
  jnwtr_ckdivn_cv_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [W-1:0] ACT_RST = W'(DIV_RST);
  localparam logic [W-1:0] DIV_MIN = W'(2);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] act_q, act_d;
  logic [W-1:0] pnd_q, pnd_d;
  logic         pend_q, pend_d;
  logic         cko_q, cko_d;
  logic         cko50_q, cko50_d;

  logic [W-1:0] div_clamp;
  logic         wrap;
  logic [W:0]   half_d;

  // State register together with the datapath flops.
  always_ff @(posedge CKI) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= ACT_RST;
      pnd_q   <= ACT_RST;
      pend_q  <= 1'b0;
      cko_q   <= 1'b0;
      cko50_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pnd_q   <= pnd_d;
      pend_q  <= pend_d;
      cko_q   <= cko_d;
      cko50_q <= cko50_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.EN)  state_d = RUN;
      RUN:     if (!bus.EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_clamp = (bus.DIV < DIV_MIN) ? DIV_MIN : bus.DIV;
  assign wrap      = (cnt_q == (act_q - 1'b1));

  always_comb begin : datapath_outputs
    cnt_d   = cnt_q;
    act_d   = act_q;
    pnd_d   = pnd_q;
    pend_d  = pend_q;
    cko_d   = 1'b0;
    cko50_d = 1'b0;
    half_d  = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.EN) begin
          if (pend_q) begin
            act_d  = pnd_q;
            pend_d = 1'b0;
          end
          cko_d = 1'b1;
        end
        // Nothing is running, so a load takes effect immediately and supersedes any retained pending ratio.
        if (bus.DIV_LD) begin
          act_d  = div_clamp;
          pend_d = 1'b0;
        end
      end

      RUN: begin
        if (!bus.EN) begin
          cnt_d = '0;
          if (bus.DIV_LD) begin
            pnd_d  = div_clamp;
            pend_d = 1'b1;
          end
        end else if (wrap) begin
          cnt_d = '0;
          cko_d = 1'b1;
          // A load coinciding with the boundary is newer than anything pending.
          if (bus.DIV_LD) begin
            act_d  = div_clamp;
            pend_d = 1'b0;
          end else if (pend_q) begin
            act_d  = pnd_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bus.DIV_LD) begin
            pnd_d  = div_clamp;
            pend_d = 1'b1;
          end
        end
      end

      default: begin
        cnt_d = '0;
      end
    endcase

    // High time follows the ratio in force after this edge, so the first period at a new ratio is already correct.
    half_d  = ({1'b0, act_d} + 1'b1) >> 1;
    cko50_d = (state_d == RUN) && ({1'b0, cnt_d} < half_d);
  end

  assign bus.CKO     = cko_q;
  assign bus.CKO50DC = cko50_q;
  assign bus.PEND    = pend_q;
  assign bus.DIV_ACT = act_q;

  a_cnt_in_range: assert property (@(posedge CKI) disable iff (RST)
    (state_q == RUN) |-> (cnt_q < act_q));

  a_act_legal: assert property (@(posedge CKI) disable iff (RST)
    (act_q >= DIV_MIN) && (pnd_q >= DIV_MIN));

endmodule
